// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: fetches one word, issues it, waits for
// execute to resolve the next PC, and parks in ERROR on a misaligned target or bus timeout.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          MAX_WAIT     = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  PCSrc2,
  input  logic [31:0] PCTarget,
  input  logic [31:0] ALUResult,
  input  logic        ex_valid,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [6:0]  op,
  output logic [2:0]  funct3,
  output logic        funct7,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] instret,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic [7:0]  wait_q, wait_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [7:0]  wait_inc;

  assign pc_plus4 = pc_q + 32'd4;
  assign wait_inc = wait_q + 8'd1;

  // JALR clears bit 0 of the computed target, as the ISA requires.
  always_comb begin
    if (PCSrc2[1]) begin
      next_pc = ALUResult & ~32'd1;
    end else if (PCSrc2[0]) begin
      next_pc = PCTarget;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instret_d  = instret_q;
    wait_d     = wait_q;
    misalign_d = misalign_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          wait_d  = 8'd0;
          state_d = ISSUE;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WAIT_LIMIT) begin
            bus_err_d = 1'b1;
            state_d   = ERROR;
          end
        end
      end
      ISSUE: begin
        // A stalled instruction holds everything; the retire counts even on a misaligned target.
        if (ex_valid && !stall) begin
          instret_d = instret_q + 32'd1;
          if (next_pc[1:0] == 2'b00) begin
            pc_d    = next_pc;
            state_d = FETCH;
          end else begin
            misalign_d = 1'b1;
            state_d    = ERROR;
          end
        end
      end
      default: begin
        state_d = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_VECTOR;
      instr_q    <= 32'd0;
      instret_q  <= 32'd0;
      wait_q     <= 8'd0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instret_q  <= instret_d;
      wait_q     <= wait_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign instr_valid  = (state_q == ISSUE);
  assign Instr        = instr_q;
  assign op           = instr_q[6:0];
  assign funct3       = instr_q[14:12];
  assign funct7       = instr_q[30];
  assign PC           = pc_q;
  assign PCPlus4      = pc_plus4;
  assign instret      = instret_q;
  assign misalign_err = misalign_q;
  assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, sequential fetch, branch, JALR, stall,
// PC wrap, fetch timeout and reset during an outstanding fetch.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [1:0]  PCSrc2;
  logic [31:0] PCTarget;
  logic [31:0] ALUResult;
  logic        ex_valid;
  logic        stall;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] instret;
  logic        misalign_err;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .MAX_WAIT    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .PCSrc2      (PCSrc2),
    .PCTarget    (PCTarget),
    .ALUResult   (ALUResult),
    .ex_valid    (ex_valid),
    .stall       (stall),
    .instr_valid (instr_valid),
    .Instr       (Instr),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .PC          (PC),
    .PCPlus4     (PCPlus4),
    .instret     (instret),
    .misalign_err(misalign_err),
    .bus_err     (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    imem_ack  = 1'b0;
    imem_rdata = 32'd0;
    ex_valid  = 1'b0;
    stall     = 1'b0;
    PCSrc2    = 2'b00;
    PCTarget  = 32'd0;
    ALUResult = 32'd0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Waits (bounded) for a fetch request, then acks it with the given word after extra_wait cycles.
  task automatic do_fetch(input logic [31:0] data, input int extra_wait);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    total++;
    if (imem_req !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fetch_wait imem_req=%b required=1", imem_req);
    end
    for (int i = 0; i < extra_wait; i++) step();
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
  endtask

  task automatic do_retire(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] alu);
    PCSrc2    = src;
    PCTarget  = tgt;
    ALUResult = alu;
    ex_valid  = 1'b1;
    step();
    ex_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0)     begin bad++; $display("[TB] FAIL rst_req actual=%b required=0", imem_req); end
    total++; if (PC !== 32'd0)          begin bad++; $display("[TB] FAIL rst_pc actual=%h required=0", PC); end
    total++; if (Instr !== 32'd0)       begin bad++; $display("[TB] FAIL rst_instr actual=%h required=0", Instr); end
    total++; if (instret !== 32'd0)     begin bad++; $display("[TB] FAIL rst_instret actual=%h required=0", instret); end
    total++; if (instr_valid !== 1'b0)  begin bad++; $display("[TB] FAIL rst_valid actual=%b required=0", instr_valid); end
    total++; if ({misalign_err, bus_err} !== 2'b00) begin bad++; $display("[TB] FAIL rst_errs actual=%b required=00", {misalign_err, bus_err}); end
    do_reset();
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL idle_req actual=%b required=0", imem_req); end
    step();
    total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL first_req actual=%b required=1", imem_req); end
  endtask

  task automatic test_sequential();
    do_reset();
    do_fetch(32'h0000_0033, 2);
    total++; if (instr_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_valid actual=%b required=1", instr_valid); end
    total++; if (op !== 7'h33)         begin bad++; $display("[TB] FAIL seq_op actual=%h required=33", op); end
    total++; if (imem_req !== 1'b0)    begin bad++; $display("[TB] FAIL seq_req_issue actual=%b required=0", imem_req); end
    do_retire(2'b00, 32'd0, 32'd0);
    total++; if (imem_addr !== 32'h4)  begin bad++; $display("[TB] FAIL seq_addr actual=%h required=4", imem_addr); end
    total++; if (instret !== 32'd1)    begin bad++; $display("[TB] FAIL seq_instret actual=%0d required=1", instret); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL seq_valid_fetch actual=%b required=0", instr_valid); end
    do_fetch(32'h4000_5013, 0);
    total++; if (funct3 !== 3'd5 || funct7 !== 1'b1) begin bad++; $display("[TB] FAIL seq_decode actual=%h/%b required=5/1", funct3, funct7); end
    total++; if (PCPlus4 !== 32'h8)    begin bad++; $display("[TB] FAIL seq_pcplus4 actual=%h required=8", PCPlus4); end
  endtask

  task automatic reach_pc8();
    do_reset();
    do_fetch(32'h13, 0);
    do_retire(2'b00, 32'd0, 32'd0);
    do_fetch(32'h13, 0);
    do_retire(2'b00, 32'd0, 32'd0);
    do_fetch(32'h63, 0);
  endtask

  task automatic test_branch();
    reach_pc8();
    total++; if (PC !== 32'h8) begin bad++; $display("[TB] FAIL br_pc8 actual=%h required=8", PC); end
    do_retire(2'b01, 32'h40, 32'd0);
    total++; if (imem_addr !== 32'h40 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL br_taken actual=%h/%b required=40/1", imem_addr, imem_req); end
    reach_pc8();
    do_retire(2'b01, 32'h42, 32'd0);
    total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL br_mis actual=%b required=1", misalign_err); end
    total++; if (PC !== 32'h8)          begin bad++; $display("[TB] FAIL br_pc_hold actual=%h required=8", PC); end
    total++; if (instret !== 32'd3)     begin bad++; $display("[TB] FAIL br_instret actual=%0d required=3", instret); end
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    step(); step(); step();
    imem_ack = 1'b0;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL br_err_park actual=%b%b required=00", imem_req, instr_valid); end
    total++; if (Instr !== 32'h63 || PC !== 32'h8) begin bad++; $display("[TB] FAIL br_err_hold actual=%h/%h required=63/8", Instr, PC); end
  endtask

  task automatic test_jalr();
    do_reset();
    do_fetch(32'h67, 0);
    do_retire(2'b10, 32'h0, 32'h0000_0101);
    total++; if (PC !== 32'h100 || misalign_err !== 1'b0) begin bad++; $display("[TB] FAIL jalr_pc actual=%h/%b required=100/0", PC, misalign_err); end
    do_fetch(32'h67, 0);
    do_retire(2'b11, 32'h0, 32'h0000_0103);
    total++; if (misalign_err !== 1'b1) begin bad++; $display("[TB] FAIL jalr_mis actual=%b required=1", misalign_err); end
    total++; if (PC !== 32'h100)        begin bad++; $display("[TB] FAIL jalr_pc_hold actual=%h required=100", PC); end
  endtask

  task automatic test_stall();
    do_reset();
    do_fetch(32'h33, 0);
    stall = 1'b1;
    ex_valid = 1'b1;
    PCSrc2 = 2'b01;
    PCTarget = 32'h80;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (PC !== 32'd0 || instret !== 32'd0 || instr_valid !== 1'b1) begin
        bad++;
        $display("[TB] FAIL stall_hold%0d actual=%h/%0d/%b required=0/0/1", i, PC, instret, instr_valid);
      end
    end
    stall = 1'b0;
    step();
    ex_valid = 1'b0;
    total++; if (PC !== 32'h80 || instret !== 32'd1) begin bad++; $display("[TB] FAIL stall_release actual=%h/%0d required=80/1", PC, instret); end
    total++; if (imem_req !== 1'b1) begin bad++; $display("[TB] FAIL stall_fetch actual=%b required=1", imem_req); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    do_fetch(32'h6F, 0);
    do_retire(2'b01, 32'hFFFF_FFFC, 32'd0);
    do_fetch(32'h13, 0);
    total++; if (PCPlus4 !== 32'd0) begin bad++; $display("[TB] FAIL wrap_plus4 actual=%h required=0", PCPlus4); end
    do_retire(2'b00, 32'd0, 32'd0);
    total++; if (PC !== 32'd0 || misalign_err !== 1'b0 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL wrap_pc actual=%h/%b/%b required=0/0/1", PC, misalign_err, imem_req); end
  endtask

  task automatic test_timeout();
    do_reset();
    step();
    for (int i = 1; i <= 16; i++) begin
      total++;
      if (imem_req !== 1'b1 || bus_err !== 1'b0) begin
        bad++;
        $display("[TB] FAIL to_cycle%0d actual=%b/%b required=1/0", i, imem_req, bus_err);
      end
      step();
    end
    total++; if (bus_err !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("[TB] FAIL to_err actual=%b/%b required=1/0", bus_err, imem_req); end
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    total++; if (Instr !== 32'd0 || instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL to_late_ack actual=%h/%b required=0/0", Instr, instr_valid); end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    step();
    step();
    reset = 1'b1;
    #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("[TB] FAIL rmf_async actual=%b required=0", imem_req); end
    step();
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    step();
    imem_ack = 1'b0;
    total++; if (Instr !== 32'd0 || instr_valid !== 1'b0) begin bad++; $display("[TB] FAIL rmf_ack actual=%h/%b required=0/0", Instr, instr_valid); end
    total++; if (imem_addr !== 32'd0 || imem_req !== 1'b1) begin bad++; $display("[TB] FAIL rmf_addr actual=%h/%b required=0/1", imem_addr, imem_req); end
  endtask

  initial begin
    reset = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = 32'd0;
    ex_valid = 1'b0;
    stall = 1'b0;
    PCSrc2 = 2'b00;
    PCTarget = 32'd0;
    ALUResult = 32'd0;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_stall();
    test_pc_wrap();
    test_timeout();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
